// File: rtl/alu_responder_if.sv
// Request/response bundle between the register controller and the ALU responder.
// The controller drives the request side and consumes the response side.
interface alu_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       alu_op_code;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             O;
  logic             C;
  logic             Z;
  logic             N;

  modport master (
    output req_valid, alu_op_code, data_a, data_b, resp_ready,
    input  req_ready, resp_valid, result, O, C, Z, N
  );

  modport slave (
    input  req_valid, alu_op_code, data_a, data_b, resp_ready,
    output req_ready, resp_valid, result, O, C, Z, N
  );
endinterface

// File: rtl/alu_responder.sv
// Multi-cycle ALU responder: one request in flight, single-cycle logic/arith ops,
// iterative SHL (one bit per cycle) and shift-add MUL (WIDTH cycles).
module alu_responder #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_responder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic [1:0]         state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [SHAMT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   res_q;
  logic               o_q, c_q, z_q, n_q;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_o, fin_c;
  logic [SHAMT_W-1:0] in_shamt;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.result     = res_q;
  assign bus.O          = o_q;
  assign bus.C          = c_q;
  assign bus.Z          = z_q;
  assign bus.N          = n_q;

  assign in_shamt = bus.data_b[SHAMT_W-1:0];
  assign add_full = {1'b0, opa} + {1'b0, opb};
  assign sub_full = {1'b0, opa} - {1'b0, opb};
  // opb is shifted right during MUL so bit 0 is always the current multiplier bit
  assign mul_next = acc + (opb[0] ? mcand : '0);

  always_comb begin
    fin_res = '0;
    fin_o   = 1'b0;
    fin_c   = 1'b0;
    case (op)
      OP_ADD: begin
        fin_res = add_full[WIDTH-1:0];
        fin_c   = add_full[WIDTH];
        fin_o   = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_full[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        fin_res = sub_full[WIDTH-1:0];
        fin_c   = ~sub_full[WIDTH];
        fin_o   = (opa[WIDTH-1] != opb[WIDTH-1]) && (sub_full[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: fin_res = opa & opb;
      OP_OR:  fin_res = opa | opb;
      OP_XOR: fin_res = opa ^ opb;
      OP_SHL: begin
        if (opb[SHAMT_W-1:0] == '0) begin
          fin_res = opa;
        end else begin
          fin_res = {acc[WIDTH-2:0], 1'b0};
          fin_c   = acc[WIDTH-1];
        end
      end
      OP_MUL: begin
        fin_res = mul_next[WIDTH-1:0];
        fin_c   = |mul_next[2*WIDTH-1:WIDTH];
        fin_o   = |mul_next[2*WIDTH-1:WIDTH];
      end
      default: fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      res_q <= '0;
      o_q   <= 1'b0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op    <= bus.alu_op_code;
            opa   <= bus.data_a;
            opb   <= bus.data_b;
            mcand <= {{WIDTH{1'b0}}, bus.data_a};
            acc   <= (bus.alu_op_code == OP_MUL) ? '0 : {{WIDTH{1'b0}}, bus.data_a};
            if (bus.alu_op_code == OP_MUL)
              cnt <= SHAMT_W'(WIDTH - 1);
            else if (bus.alu_op_code == OP_SHL && in_shamt != '0)
              cnt <= in_shamt - SHAMT_W'(1);
            else
              cnt <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res_q <= fin_res;
            o_q   <= fin_o;
            c_q   <= fin_c;
            z_q   <= (fin_res == '0);
            n_q   <= fin_res[WIDTH-1];
            state <= DONE;
          end else begin
            cnt <= cnt - SHAMT_W'(1);
            if (op == OP_SHL) begin
              acc <= {acc[2*WIDTH-2:0], 1'b0};
            end else if (op == OP_MUL) begin
              acc   <= mul_next;
              mcand <= {mcand[2*WIDTH-2:0], 1'b0};
              opb   <= {1'b0, opb[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// Randomized + directed bench for alu_responder against an arithmetic reference model.
module tb_alu_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_responder_if #(.WIDTH(32)) bus ();

  alu_responder #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] ocz_n, output int lat);
    logic [63:0] p;
    logic o, c;
    int sh;
    o = 1'b0; c = 1'b0; lat = 1; r = '0;
    case (op)
      3'd0: begin
        p = 64'(a) + 64'(b);
        r = p[31:0]; c = p[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd7: begin
        r = a - b; c = (a >= b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        sh = int'(b[4:0]);
        if (sh == 0) begin
          r = a;
        end else begin
          p = 64'(a) << sh;
          r = p[31:0]; c = p[32]; lat = sh;
        end
      end
      default: begin
        p = 64'(a) * 64'(b);
        r = p[31:0]; c = (p[63:32] != 0); o = c; lat = 32;
      end
    endcase
    ocz_n = {o, c, (r == 0), r[31]};
  endtask

  // hold: cycles DONE is held with resp_ready low; early: resp_ready high from accept on
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit early, input bit noise);
    logic [31:0] er;
    logic [3:0]  ef;
    int el, cyc;
    model(op, a, b, er, ef, el);
    chk("idle_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.alu_op_code = op; bus.data_a = a; bus.data_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.data_a = $urandom; bus.data_b = $urandom; bus.alu_op_code = 3'($urandom);
    bus.resp_ready = early;
    cyc = 0;
    while (!bus.resp_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(el));
    chk("result", bus.result, er);
    chk("flags_OCZN", {bus.O, bus.C, bus.Z, bus.N}, ef);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        chk("busy_ready", bus.req_ready, 0);
        if (noise) begin
          bus.req_valid = 1'($urandom_range(0, 1));
          bus.data_a = $urandom; bus.data_b = $urandom; bus.alu_op_code = 3'($urandom);
        end
        @(posedge clk); #1;
        chk("hold_valid", bus.resp_valid, 1);
        chk("hold_result", bus.result, er);
        chk("hold_flags", {bus.O, bus.C, bus.Z, bus.N}, ef);
      end
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_drop", bus.resp_valid, 0);
    chk("ready_back", bus.req_ready, 1);
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.alu_op_code = '0;
    bus.data_a = '0; bus.data_b = '0;
    #12;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.O, bus.C, bus.Z, bus.N}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b1, 1'b0);
    run_op(3'd1, 32'd5, 32'd5, 1, 1'b0, 1'b0);
    run_op(3'd7, 32'd3, 32'd7, 0, 1'b0, 1'b0);
    run_op(3'd6, 32'h0001_0000, 32'h0001_0000, 0, 1'b1, 1'b0);
    run_op(3'd6, 32'd6, 32'd7, 2, 1'b0, 1'b0);
    run_op(3'd5, 32'h8000_0001, 32'd1, 0, 1'b0, 1'b0);
    run_op(3'd5, 32'd1, 32'd4, 0, 1'b0, 1'b0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 1'b0, 1'b0);
    run_op(3'd0, 32'd1, 32'd2, 5, 1'b0, 1'b1);
    // nothing queued from the noise requests above
    @(posedge clk); #1;
    chk("no_queued", bus.resp_valid, 0);

    // abort a MUL mid-flight
    bus.req_valid = 1'b1; bus.alu_op_code = 3'd6;
    bus.data_a = 32'hFFFF_FFFF; bus.data_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_valid", bus.resp_valid, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_flags", {bus.O, bus.C, bus.Z, bus.N}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", bus.resp_valid, 0);
    run_op(3'd0, 32'd1, 32'd2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      if (k % 5 == 0) ra = (k % 10 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      if (k % 7 == 0) rb = ra;
      if (rop == 3'd6 && k % 3 == 0) begin
        ra = ra & 32'hFFFF; rb = rb & 32'hFFFF;
      end
      run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
